// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative 32-bit signed/unsigned radix-2 restoring divider
//               for the execute stage (DIV/DIVU -> LO/HI). Fixed 32-cycle
//               latency from the accept edge, valid/ready on input and
//               output, synchronous flush via cancel.
// Ports       : clk        - clock, rising edge
//               resetn     - synchronous reset, active low
//               div_valid  - operand request        div_ready - can accept
//               div_signed - 1 = DIV, 0 = DIVU
//               x, y       - dividend, divisor
//               cancel     - kill any operation (wins over everything)
//               out_valid  - result available       out_ready - result taken
//               s, r       - quotient (LO), remainder (HI)
//               div_zero   - result came from a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        div_valid,
    output logic        div_ready,
    input  logic        div_signed,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cancel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] s,
    output logic [31:0] r,
    output logic        div_zero
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    localparam logic [4:0] LAST_ITR = 5'd31;

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;      // dividend magnitude, consumed MSB first
    logic [31:0] dvs_q;      // divisor magnitude
    logic [31:0] rem_q;      // partial remainder (always < divisor)
    logic [31:0] quo_q;      // quotient shift register
    logic        sgnq_q, sgnr_q, zero_q;
    logic [31:0] xraw_q;
    logic [31:0] s_q, r_q;
    logic        dz_q;

    logic        w_accept;
    logic        w_last;
    logic [31:0] w_x_mag, w_y_mag;
    logic [32:0] w_partial, w_trial;
    logic        w_take;
    logic [31:0] w_rem_nx, w_quo_nx;
    logic [31:0] w_s_fin, w_r_fin;
    logic        w_unused_msb;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (cancel) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (div_valid)        state_d = S_BUSY;
                S_BUSY:  if (cnt_q == LAST_ITR) state_d = S_DONE;
                S_DONE:  if (out_ready)        state_d = S_IDLE;
                default:                       state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- output logic (registered state only) ----------------
    always_comb begin
        div_ready = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        s         = s_q;
        r         = r_q;
        div_zero  = dz_q;
    end

    // ---------------- datapath ----------------
    assign w_accept = (state_q == S_IDLE) && div_valid && !cancel;
    assign w_last   = (state_q == S_BUSY) && !cancel && (cnt_q == LAST_ITR);

    // Negating 0x80000000 yields 0x80000000, which read as unsigned is the
    // correct magnitude 2^31.
    assign w_x_mag = (div_signed && x[31]) ? (32'd0 - x) : x;
    assign w_y_mag = (div_signed && y[31]) ? (32'd0 - y) : y;

    // The remainder stays below the divisor, so it fits in 32 bits; the
    // shifted-in partial needs 33. A borrow out of bit 32 means "doesn't fit".
    assign w_partial    = {rem_q, dvd_q[31]};
    assign w_trial      = w_partial - {1'b0, dvs_q};
    assign w_take       = ~w_trial[32];
    assign w_rem_nx     = w_take ? w_trial[31:0] : w_partial[31:0];
    assign w_quo_nx     = {quo_q[30:0], w_take};
    assign w_unused_msb = w_partial[32];

    assign w_s_fin = zero_q ? 32'hFFFF_FFFF
                            : (sgnq_q ? (32'd0 - w_quo_nx) : w_quo_nx);
    assign w_r_fin = zero_q ? xraw_q
                            : (sgnr_q ? (32'd0 - w_rem_nx) : w_rem_nx);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= 5'd0;
            dvd_q  <= 32'd0;
            dvs_q  <= 32'd0;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            sgnq_q <= 1'b0;
            sgnr_q <= 1'b0;
            zero_q <= 1'b0;
            xraw_q <= 32'd0;
            s_q    <= 32'd0;
            r_q    <= 32'd0;
            dz_q   <= 1'b0;
        end else if (w_accept) begin
            cnt_q  <= 5'd0;
            dvd_q  <= w_x_mag;
            dvs_q  <= w_y_mag;
            rem_q  <= 32'd0;
            quo_q  <= 32'd0;
            sgnq_q <= div_signed & (x[31] ^ y[31]);
            sgnr_q <= div_signed & x[31];
            zero_q <= (y == 32'd0);
            xraw_q <= x;
        end else if ((state_q == S_BUSY) && !cancel) begin
            cnt_q <= cnt_q + 5'd1;
            dvd_q <= {dvd_q[30:0], 1'b0};
            rem_q <= w_rem_nx;
            quo_q <= w_quo_nx;
            if (w_last) begin
                s_q  <= w_s_fin;
                r_q  <= w_r_fin;
                dz_q <= zero_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_iter
// Description : Self-checking directed bench for div_iter, followed by a
//               back-to-back random run checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        div_valid;
    logic        div_ready;
    logic        div_signed;
    logic [31:0] x, y;
    logic        cancel;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s, r;
    logic        div_zero;

    int n_chk = 0;
    int n_err = 0;

    localparam int N_RAND = 60;

    div_iter dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .div_ready  (div_ready),
        .div_signed (div_signed),
        .x          (x),
        .y          (y),
        .cancel     (cancel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .s          (s),
        .r          (r),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present operands at a negedge; the following rising edge is the accept edge.
    task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        div_signed = sg;
        x          = a;
        y          = b;
        div_valid  = 1'b1;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        x          = $urandom;   // must be ignored from here on
        y          = $urandom;
        div_signed = ~sg;
    endtask

    // Number of rising edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if (out_valid) break;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_out_valid", 32'(out_valid), 32'd0);
        chk("consume_div_ready", 32'(div_ready), 32'd1);
    endtask

    task automatic run(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] es,
                       input logic [31:0] er, input logic ez);
        int lat;
        issue(sg, a, b);
        chk({tag, "_busy"}, 32'(div_ready), 32'd0);
        wait_done(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd32);
        chk({tag, "_s"}, s, es);
        chk({tag, "_r"}, r, er);
        chk({tag, "_zero"}, 32'(div_zero), 32'(ez));
        consume();
    endtask

    // Count out_valid assertions over a window; used to prove nothing emerges.
    task automatic watch_quiet(input string tag);
        int seen;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    function automatic void ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] rm,
                                    output logic z);
        z = 1'b0;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            rm = a;
            z  = 1'b1;
        end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q  = 32'h8000_0000;
            rm = 32'd0;
        end else if (sg) begin
            q  = $signed(a) / $signed(b);
            rm = $signed(a) % $signed(b);
        end else begin
            q  = a / b;
            rm = a % b;
        end
    endfunction

    initial begin
        int          lat;
        logic [31:0] q_s[$], q_r[$];
        logic        q_z[$];
        logic [31:0] ra, rb, es, er;
        logic        rsg, ez;
        int          last_acc, cyc, n_iss, n_done;

        resetn     = 1'b0;
        div_valid  = 1'b0;
        div_signed = 1'b0;
        x          = 32'd0;
        y          = 32'd0;
        cancel     = 1'b0;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_div_ready", 32'(div_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", s, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Basic and sign-rule vectors
        run("divu_100_7",   1'b0, 32'd100,       32'd7,          32'd14,        32'd2,        1'b0);
        run("div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run("div_7_m2",     1'b1, 32'd7,         32'hFFFF_FFFE,  32'hFFFF_FFFD, 32'd1,        1'b0);
        run("divu_big_2",   1'b0, 32'hFFFF_FFF9, 32'd2,          32'h7FFF_FFFC, 32'd1,        1'b0);
        run("div_ovf",      1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, 32'd0,        1'b0);
        run("div_by_zero",  1'b1, 32'd5,         32'd0,          32'hFFFF_FFFF, 32'd5,        1'b1);
        run("divu_by_zero", 1'b0, 32'h8000_0001, 32'd0,          32'hFFFF_FFFF, 32'h8000_0001, 1'b1);
        run("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1,         32'd0,        1'b0);
        run("div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,  32'd14,        32'hFFFF_FFFE, 1'b0);

        // Backpressure: hold result for 10 cycles, stray div_valid ignored
        issue(1'b0, 32'd1000, 32'd10);
        wait_done(lat);
        chk("bp_latency", 32'(lat), 32'd32);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 4) begin
                div_valid  = 1'b1;
                div_signed = 1'b0;
                x          = 32'd3;
                y          = 32'd1;
            end else begin
                div_valid  = 1'b0;
            end
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_s", s, 32'd100);
            chk("bp_r", r, 32'd0);
            chk("bp_div_ready", 32'(div_ready), 32'd0);
        end
        consume();
        watch_quiet("bp_no_stray_result");
        chk("bp_idle_after", 32'(div_ready), 32'd1);

        // Cancel during iteration 15
        issue(1'b1, 32'd12345, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_mid_ready", 32'(div_ready), 32'd1);
        chk("cancel_mid_valid", 32'(out_valid), 32'd0);
        watch_quiet("cancel_mid_no_result");

        // Cancel together with div_valid in IDLE
        @(negedge clk);
        div_valid  = 1'b1;
        cancel     = 1'b1;
        div_signed = 1'b0;
        x          = 32'd9;
        y          = 32'd3;
        @(posedge clk);
        #1;
        div_valid  = 1'b0;
        cancel     = 1'b0;
        chk("cancel_idle_ready", 32'(div_ready), 32'd1);
        watch_quiet("cancel_idle_no_result");

        // Cancel in DONE with out_ready high: result discarded
        issue(1'b0, 32'd77, 32'd7);
        wait_done(lat);
        chk("cancel_done_latency", 32'(lat), 32'd32);
        @(negedge clk);
        cancel    = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        cancel    = 1'b0;
        out_ready = 1'b0;
        chk("cancel_done_valid", 32'(out_valid), 32'd0);
        chk("cancel_done_ready", 32'(div_ready), 32'd1);

        // Reset while holding a result
        issue(1'b0, 32'd50, 32'd3);
        wait_done(lat);
        chk("rstdone_s_before", s, 32'd16);
        chk("rstdone_r_before", r, 32'd2);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        chk("rstdone_out_valid", 32'(out_valid), 32'd0);
        chk("rstdone_s", s, 32'd0);
        chk("rstdone_r", r, 32'd0);
        chk("rstdone_div_zero", 32'(div_zero), 32'd0);
        chk("rstdone_div_ready", 32'(div_ready), 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back random operations, out_ready tied high
        out_ready = 1'b1;
        last_acc  = -1;
        cyc       = 0;
        n_iss     = 0;
        n_done    = 0;
        for (int c = 0; c < N_RAND * 34 + 100 && n_done < N_RAND; c++) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (q_s.size() > 0) begin
                    es = q_s.pop_front();
                    er = q_r.pop_front();
                    ez = q_z.pop_front();
                    chk("rand_s", s, es);
                    chk("rand_r", r, er);
                    chk("rand_zero", 32'(div_zero), 32'(ez));
                end else begin
                    chk("rand_unexpected_result", 32'd1, 32'(q_s.size()));
                end
                n_done++;
            end
            if (div_ready && n_iss < N_RAND) begin
                if (last_acc >= 0) chk("rand_interval", 32'(cyc - last_acc), 32'd34);
                last_acc = cyc;
                rsg = 1'($urandom);
                ra  = $urandom;
                rb  = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = rb >> $urandom_range(16, 31);
                    1:       rb = rb >> $urandom_range(1, 15);
                    2:       if ($urandom_range(0, 4) == 0) rb = 32'd0;
                    default: ;
                endcase
                ref_div(rsg, ra, rb, es, er, ez);
                q_s.push_back(es);
                q_r.push_back(er);
                q_z.push_back(ez);
                div_signed = rsg;
                x          = ra;
                y          = rb;
                div_valid  = 1'b1;
                n_iss++;
            end else if (n_iss >= N_RAND) begin
                div_valid = 1'b0;
            end
        end
        chk("rand_all_done", 32'(n_done), 32'(N_RAND));
        out_ready = 1'b0;
        div_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
